list_fold_sum: RTL and testbench

- Downstream consumer of a dataflow list producer, e.g. a range generator driven with bounds 10 and 20.
- Pulls elements over the list req/ack/eol/value handshake and folds them with integer addition.
- Presents the result on the standard function interface: ready in, done out, result.
- Also drives the producer's ready, so one start from the parent runs the whole list.

---
 rtl/list_fold_sum.sv | 149 ++++++++++++++
 tb/tb_list_fold_sum.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/list_fold_sum.sv
`default_nettype none
// list_fold_sum: pulls elements from a req/ack/eol list producer and folds them with wrapping addition.
// Optional macro FOLD_TIMEOUT_EN adds an ack timeout ending the call in an error state (port err).
module list_fold_sum #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
`ifdef FOLD_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 1024
`endif
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ready,
    output logic              done,
    output logic [ACC_W-1:0]  result,
    output logic [15:0]       count,
    output logic              list_ready,
    output logic              req,
    input  logic              ack,
    input  logic              eol,
    input  logic [DATA_W-1:0] value
`ifdef FOLD_TIMEOUT_EN
    ,
    output logic              err
`endif
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        GAP  = 3'd2,
`ifdef FOLD_TIMEOUT_EN
        ERR  = 3'd4,
`endif
        DONE = 3'd3
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;

`ifdef FOLD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] wait_cnt;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            done       <= 1'b0;
            req        <= 1'b0;
            list_ready <= 1'b0;
            result     <= '0;
            acc        <= '0;
            count      <= '0;
`ifdef FOLD_TIMEOUT_EN
            err        <= 1'b0;
            wait_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (ready) begin
                        state      <= REQ;
                        acc        <= '0;
                        count      <= '0;
                        list_ready <= 1'b1;
                        req        <= 1'b1;
`ifdef FOLD_TIMEOUT_EN
                        wait_cnt   <= '0;
`endif
                    end
                end

                // A ready drop wins over a simultaneous ack: the call is abandoned.
                REQ: begin
                    if (!ready) begin
                        state      <= IDLE;
                        req        <= 1'b0;
                        list_ready <= 1'b0;
                    end else if (ack && !eol) begin
                        acc   <= acc + ACC_W'(value);
                        count <= count + 16'd1;
                        req   <= 1'b0;
                        state <= GAP;
                    end else if (ack) begin
                        result <= acc;
                        done   <= 1'b1;
                        req    <= 1'b0;
                        state  <= DONE;
                    end
`ifdef FOLD_TIMEOUT_EN
                    else if (wait_cnt == TO_W'(TIMEOUT - 1)) begin
                        state  <= ERR;
                        req    <= 1'b0;
                        done   <= 1'b1;
                        err    <= 1'b1;
                        result <= '1;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
`endif
                end

                // Wait for the producer to release ack before the next request.
                GAP: begin
                    if (!ready) begin
                        state      <= IDLE;
                        list_ready <= 1'b0;
                    end else if (!ack) begin
                        state <= REQ;
                        req   <= 1'b1;
`ifdef FOLD_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end

                DONE: begin
                    if (!ready) begin
                        state      <= IDLE;
                        done       <= 1'b0;
                        list_ready <= 1'b0;
                    end
                end

`ifdef FOLD_TIMEOUT_EN
                ERR: begin
                    if (!ready) begin
                        state      <= IDLE;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        list_ready <= 1'b0;
                    end
                end
`endif

                default: begin
                    state      <= IDLE;
                    req        <= 1'b0;
                    done       <= 1'b0;
                    list_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_list_fold_sum.sv
`default_nettype none
// tb_list_fold_sum: randomized producer against a call-level reference model; a 16-bit and an
// 8-bit accumulator instance share the same stimulus so wrap-around is observed directly.
module tb_list_fold_sum;

    localparam int TIMEOUT = 16;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ready = 1'b0;
    logic        ack = 1'b0;
    logic        eol = 1'b0;
    logic [7:0]  value = 8'd0;

    logic        done, req, list_ready;
    logic [15:0] result, count;
    logic        done8, req8, lr8;
    logic [7:0]  result8;
    logic [15:0] count8;
`ifdef FOLD_TIMEOUT_EN
    logic        err, err8;
`endif

    always #5 clock = ~clock;

    list_fold_sum #(
        .DATA_W(8), .ACC_W(16)
`ifdef FOLD_TIMEOUT_EN
        , .TIMEOUT(TIMEOUT)
`endif
    ) dut (
        .clock(clock), .reset_n(reset_n), .ready(ready), .done(done), .result(result),
        .count(count), .list_ready(list_ready), .req(req), .ack(ack), .eol(eol), .value(value)
`ifdef FOLD_TIMEOUT_EN
        , .err(err)
`endif
    );

    list_fold_sum #(
        .DATA_W(8), .ACC_W(8)
`ifdef FOLD_TIMEOUT_EN
        , .TIMEOUT(TIMEOUT)
`endif
    ) dut8 (
        .clock(clock), .reset_n(reset_n), .ready(ready), .done(done8), .result(result8),
        .count(count8), .list_ready(lr8), .req(req8), .ack(ack), .eol(eol), .value(value)
`ifdef FOLD_TIMEOUT_EN
        , .err(err8)
`endif
    );

    int errors = 0;
    int checks = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model: what the caller should observe, tracked per call phase.
    typedef enum int {M_IDLE, M_ASK, M_GAP, M_END, M_ERR} mphase_t;
    mphase_t     ph = M_IDLE;
    int unsigned m_sum = 0;
    int unsigned m_res = 0;
    int          m_cnt = 0;
    int          m_wait = 0;
    bit          m_done = 0, m_req = 0, m_lr = 0, m_err = 0;

    task automatic model_step();
        if (!reset_n) begin
            ph = M_IDLE; m_sum = 0; m_res = 0; m_cnt = 0;
            m_done = 0; m_req = 0; m_lr = 0; m_err = 0;
            return;
        end
        case (ph)
            M_IDLE: if (ready) begin
                ph = M_ASK; m_sum = 0; m_cnt = 0; m_lr = 1; m_req = 1; m_wait = 0;
            end
            M_ASK: begin
                if (!ready) begin
                    ph = M_IDLE; m_req = 0; m_lr = 0;
                end else if (ack && !eol) begin
                    m_sum += value; m_cnt = (m_cnt + 1) % 65536; m_req = 0; ph = M_GAP;
                end else if (ack) begin
                    m_res = m_sum; m_done = 1; m_req = 0; ph = M_END;
                end else begin
`ifdef FOLD_TIMEOUT_EN
                    m_wait++;
                    if (m_wait == TIMEOUT) begin
                        ph = M_ERR; m_req = 0; m_done = 1; m_err = 1; m_res = 32'hFFFF_FFFF;
                    end
`endif
                end
            end
            M_GAP: begin
                if (!ready) begin
                    ph = M_IDLE; m_req = 0; m_lr = 0;
                end else if (!ack) begin
                    ph = M_ASK; m_req = 1; m_wait = 0;
                end
            end
            M_END, M_ERR: if (!ready) begin
                ph = M_IDLE; m_done = 0; m_lr = 0; m_err = 0;
            end
            default: ph = M_IDLE;
        endcase
    endtask

    task automatic compare();
        chk("done", done, m_done);
        chk("req", req, m_req);
        chk("list_ready", list_ready, m_lr);
        chk("result", result, m_res & 32'hFFFF);
        chk("count", count, m_cnt);
        chk("done8", done8, m_done);
        chk("req8", req8, m_req);
        chk("list_ready8", lr8, m_lr);
        chk("result8", result8, m_res & 32'hFF);
        chk("count8", count8, m_cnt);
`ifdef FOLD_TIMEOUT_EN
        chk("err", err, m_err);
        chk("err8", err8, m_err);
`endif
    endtask

    // Producer: answers req after a random delay, holds ack a random number of cycles.
    int q[$];
    bit prod_on = 1;
    int delay_left = 0, hold_left = 0;
    int max_delay = 0, min_hold = 0, max_hold = 0;

    task automatic producer_step();
        if (ack) begin
            if (hold_left > 0) hold_left--;
            else begin
                ack = 0; eol = 1'($urandom_range(0, 1)); value = 8'($urandom);
            end
        end else if (prod_on && req) begin
            if (delay_left > 0) delay_left--;
            else begin
                ack = 1;
                if (q.size() == 0) begin eol = 1; value = 8'($urandom); end
                else begin eol = 0; value = 8'(q.pop_front()); end
                delay_left = $urandom_range(0, max_delay);
                hold_left  = $urandom_range(min_hold, max_hold);
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
        compare();
        producer_step();
    endtask

    task automatic run_call(input int budget);
        int n;
        n = 0;
        ready = 1;
        while (!m_done && n < budget) begin cycle(); n++; end
        chk("call_completes", m_done, 1);
    endtask

    task automatic end_call();
        ready = 0;
        cycle();
        cycle();
    endtask

    initial begin
        int n;
        int abort_at;
        bit aborted;

        reset_n = 0;
        repeat (3) cycle();
        chk("reset_done", done, 0);
        chk("reset_req", req, 0);
        chk("reset_result", result, 0);
        reset_n = 1;
        cycle();

        // 10..20 with one-cycle ack latency
        q.delete();
        for (int v = 10; v <= 20; v++) q.push_back(v);
        run_call(200);
        chk("sum_10_20", result, 165);
        chk("count_10_20", count, 11);
        chk("model_sum_10_20", m_res, 165);
        end_call();

        // Empty list
        q.delete();
        run_call(20);
        chk("empty_result", result, 0);
        chk("empty_count", count, 0);
        end_call();

        // Wrap in the 8-bit instance
        q.delete(); q.push_back(200); q.push_back(100);
        run_call(50);
        chk("wrap8_result", result8, 44);
        chk("model_wrap8", m_res & 32'hFF, 44);
        chk("wide_result", result, 300);
        chk("wrap8_count", count8, 2);
        end_call();

        // Abort after three elements, then a clean call
        q.delete();
        for (int v = 5; v <= 9; v++) q.push_back(v);
        ready = 1; n = 0;
        while (m_cnt < 3 && n < 100) begin cycle(); n++; end
        chk("abort_reached3", m_cnt, 3);
        ready = 0;
        cycle();
        chk("abort_req", req, 0);
        chk("abort_list_ready", list_ready, 0);
        repeat (3) cycle();
        chk("abort_no_done", done, 0);
        ack = 0; eol = 0; hold_left = 0; delay_left = 0;
        q.delete(); q.push_back(1); q.push_back(2); q.push_back(3);
        run_call(50);
        chk("after_abort_sum", result, 6);
        chk("model_after_abort", m_res, 6);
        end_call();

        // Reset while in GAP with ack held high
        q.delete(); q.push_back(4); q.push_back(5); q.push_back(6);
        min_hold = 2; max_hold = 3;
        ready = 1; n = 0;
        while (!(ph == M_GAP && ack) && n < 100) begin cycle(); n++; end
        chk("gap_with_ack_seen", (ph == M_GAP && ack), 1);
        reset_n = 0;
        cycle();
        chk("rst_gap_done", done, 0);
        chk("rst_gap_req", req, 0);
        chk("rst_gap_list_ready", list_ready, 0);
        chk("rst_gap_result", result, 0);
        chk("rst_gap_count", count, 0);
        reset_n = 1; ready = 0; ack = 0; min_hold = 0; max_hold = 0; hold_left = 0;
        cycle();
        q.delete(); q.push_back(7);
        run_call(50);
        chk("after_reset_sum", result, 7);
        end_call();

        // Randomized calls
        for (int c = 0; c < 40; c++) begin
            q.delete();
            for (int k = 0; k < $urandom_range(0, 8); k++) q.push_back($urandom_range(0, 255));
            max_delay = $urandom_range(0, 3);
            max_hold = $urandom_range(0, 2);
            delay_left = 0; hold_left = 0;
            abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : -1;
            aborted = 0;
            ready = 1; n = 0;
            while (!m_done && n < 200) begin
                if (n == abort_at) begin ready = 0; aborted = 1; end
                cycle(); n++;
                if (aborted) break;
                if ($urandom_range(0, 150) == 0) begin
                    reset_n = 0; cycle(); reset_n = 1;
                end
            end
            if (!aborted) chk("rand_call_done", m_done, 1);
            ready = 0;
            repeat ($urandom_range(1, 3)) cycle();
            if ($urandom_range(0, 3) == 0) begin
                ack = 1; eol = 1'($urandom_range(0, 1)); value = 8'($urandom);
                cycle();
            end
        end
        ack = 0; max_delay = 0; max_hold = 0;
        repeat (3) cycle();

`ifdef FOLD_TIMEOUT_EN
        // Producer never answers
        prod_on = 0; ack = 0;
        ready = 1;
        cycle();
        chk("timeout_req_up", req, 1);
        n = 0;
        while (!m_err && n < 40) begin cycle(); n++; end
        chk("timeout_cycles", n, 16);
        chk("timeout_err", err, 1);
        chk("timeout_result", result, 16'hFFFF);
        chk("timeout_req", req, 0);
        end_call();
        prod_on = 1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
